// File: rtl/psg_bus_sequencer.sv
// PSG bus sequencer: arbitrates CPU and player register accesses onto the
// BDIR/BC/DA bus of a PSG. Each transaction runs LATCH -> ACCESS -> GAP.
// Optional feature macro: ADDR_CACHE_EN. When it is defined, the last latched
// register number is remembered and a repeat access skips the LATCH phase.
module psg_bus_sequencer (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CPU_REQ,
  input  logic       CPU_WR,
  input  logic [3:0] CPU_ADDR,
  input  logic [7:0] CPU_WDATA,
  output logic       CPU_ACK,
  output logic [7:0] CPU_RDATA,
  input  logic       PLY_REQ,
  input  logic       PLY_WR,
  input  logic [3:0] PLY_ADDR,
  input  logic [7:0] PLY_WDATA,
  output logic       PLY_ACK,
  output logic [7:0] PLY_RDATA,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] PSG_DI,
  input  logic [7:0] PSG_DO,
  output logic       BUSY
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ACCESS, S_GAP} state_e;

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            gnt_ply_q, gnt_ply_d;
  logic            ply_next_q, ply_next_d;
  logic            bdir_q, bdir_d;
  logic            bc_q, bc_d;
  logic [DW-1:0]   di_q, di_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            ply_ack_q, ply_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   ply_rdata_q, ply_rdata_d;
  logic            busy_q, busy_d;
  logic            sel_ply_c;
  logic            hit_c;
`ifdef ADDR_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [AW-1:0]   cache_addr_q, cache_addr_d;
`endif

  // State and registered bus/handshake outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_ply_q   <= 1'b0;
      ply_next_q  <= 1'b0;
      bdir_q      <= 1'b0;
      bc_q        <= 1'b0;
      di_q        <= '0;
      cpu_ack_q   <= 1'b0;
      ply_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ply_rdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef ADDR_CACHE_EN
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_ply_q   <= gnt_ply_d;
      ply_next_q  <= ply_next_d;
      bdir_q      <= bdir_d;
      bc_q        <= bc_d;
      di_q        <= di_d;
      cpu_ack_q   <= cpu_ack_d;
      ply_ack_q   <= ply_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ply_rdata_q <= ply_rdata_d;
      busy_q      <= busy_d;
`ifdef ADDR_CACHE_EN
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
`endif
    end
  end

  // Arbitration, sequencing, and bus outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_ply_d   = gnt_ply_q;
    ply_next_d  = ply_next_q;
    bdir_d      = 1'b0;
    bc_d        = 1'b0;
    di_d        = di_q;
    cpu_ack_d   = 1'b0;
    ply_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ply_rdata_d = ply_rdata_q;
    hit_c       = 1'b0;
`ifdef ADDR_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
`endif
    // Player wins only when alone or when it is its turn
    sel_ply_c   = PLY_REQ && (!CPU_REQ || ply_next_q);

    case (state_q)
      S_IDLE: begin
        if (CPU_REQ || PLY_REQ) begin
          gnt_ply_d  = sel_ply_c;
          ply_next_d = !sel_ply_c;
          wr_d       = sel_ply_c ? PLY_WR    : CPU_WR;
          addr_d     = sel_ply_c ? PLY_ADDR  : CPU_ADDR;
          wdata_d    = sel_ply_c ? PLY_WDATA : CPU_WDATA;
`ifdef ADDR_CACHE_EN
          hit_c      = cache_vld_q && (cache_addr_q == addr_d);
`endif
          state_d    = hit_c ? S_ACCESS : S_LATCH;
        end
      end
      S_LATCH:  state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_GAP;
        if (gnt_ply_q) ply_rdata_d = wr_q ? '0 : PSG_DO;
        else           cpu_rdata_d = wr_q ? '0 : PSG_DO;
      end
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_LATCH: begin
        bdir_d = 1'b1;
        bc_d   = 1'b1;
        di_d   = DW'(addr_d);
`ifdef ADDR_CACHE_EN
        cache_vld_d  = 1'b1;
        cache_addr_d = addr_d;
`endif
      end
      S_ACCESS: begin
        if (wr_d) begin
          bdir_d = 1'b1;
          di_d   = wdata_d;
        end else begin
          bc_d   = 1'b1;
        end
      end
      S_GAP: begin
        cpu_ack_d = !gnt_ply_d;
        ply_ack_d = gnt_ply_d;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign BDIR      = bdir_q;
  assign BC        = bc_q;
  assign PSG_DI    = di_q;
  assign CPU_ACK   = cpu_ack_q;
  assign PLY_ACK   = ply_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign PLY_RDATA = ply_rdata_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Self-checking bench for psg_bus_sequencer: a PSG register-file model sits
// on the bus, and a transaction-level reference predicts bus phases, latency,
// read data and per-requester RDATA retention.
module tb_psg_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CPU_REQ, CPU_WR, PLY_REQ, PLY_WR;
  logic [3:0] CPU_ADDR, PLY_ADDR;
  logic [7:0] CPU_WDATA, PLY_WDATA;
  logic       CPU_ACK, PLY_ACK;
  logic [7:0] CPU_RDATA, PLY_RDATA;
  logic       BDIR, BC, BUSY;
  logic [7:0] PSG_DI, PSG_DO;

  psg_bus_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .PLY_REQ(PLY_REQ), .PLY_WR(PLY_WR), .PLY_ADDR(PLY_ADDR), .PLY_WDATA(PLY_WDATA),
    .PLY_ACK(PLY_ACK), .PLY_RDATA(PLY_RDATA),
    .BDIR(BDIR), .BC(BC), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // PSG chip model: latch on 11, write on 10, drive register on 01
  logic [7:0] psg_mem [16];
  logic [3:0] psg_addr;
  always @(posedge CLK) begin
    if (BDIR && BC)       psg_addr <= PSG_DI[3:0];
    else if (BDIR && !BC) psg_mem[psg_addr] <= PSG_DI;
  end
  assign PSG_DO = (!BDIR && BC) ? psg_mem[psg_addr] : 8'hFF;

  // Reference state at transaction level
  logic [7:0] m_mem [16];
  logic [7:0] m_rdata [2];
  logic [7:0] m_di;
`ifdef ADDR_CACHE_EN
  bit         m_cache_vld;
  logic [3:0] m_cache_addr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input bit ply, input bit req, input bit wr,
                         input logic [3:0] addr, input logic [7:0] wdata);
    if (ply) begin
      PLY_REQ = req; PLY_WR = wr; PLY_ADDR = addr; PLY_WDATA = wdata;
    end else begin
      CPU_REQ = req; CPU_WR = wr; CPU_ADDR = addr; CPU_WDATA = wdata;
    end
  endtask

  task automatic model_reset();
    m_di       = 8'h00;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
`ifdef ADDR_CACHE_EN
    m_cache_vld = 1'b0;
`endif
  endtask

  // One isolated transaction from IDLE; checks every cycle up to the idle return
  task automatic do_txn(input bit ply, input bit wr, input logic [3:0] addr, input logic [7:0] wdata);
    bit         lat_en;
    int         n;
    logic [7:0] exp_rd, exp_di;
    lat_en = 1'b1;
`ifdef ADDR_CACHE_EN
    if (m_cache_vld && m_cache_addr == addr) lat_en = 1'b0;
`endif
    n      = lat_en ? 3 : 2;
    exp_rd = wr ? 8'h00 : m_mem[addr];
    exp_di = lat_en ? {4'h0, addr} : m_di;
    set_req(ply, 1'b1, wr, addr, wdata);
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK); #1;
      if (k == 1) set_req(ply, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
      check_val("busy", 8'(BUSY), 8'd1);
      check_val("other_ack", 8'(ply ? CPU_ACK : PLY_ACK), 8'd0);
      if (lat_en && k == 1) begin
        check_val("latch_bdir", 8'(BDIR), 8'd1);
        check_val("latch_bc", 8'(BC), 8'd1);
        check_val("latch_di", PSG_DI, exp_di);
        check_val("latch_ack", 8'(ply ? PLY_ACK : CPU_ACK), 8'd0);
      end else if (k < n) begin
        if (wr) exp_di = wdata;
        check_val("access_bdir", 8'(BDIR), 8'(wr));
        check_val("access_bc", 8'(BC), 8'(!wr));
        check_val("access_di", PSG_DI, exp_di);
        check_val("access_ack", 8'(ply ? PLY_ACK : CPU_ACK), 8'd0);
      end else begin
        check_val("gap_bdir", 8'(BDIR), 8'd0);
        check_val("gap_bc", 8'(BC), 8'd0);
        check_val("gap_di", PSG_DI, exp_di);
        check_val("gap_ack", 8'(ply ? PLY_ACK : CPU_ACK), 8'd1);
        check_val("gap_rdata", ply ? PLY_RDATA : CPU_RDATA, exp_rd);
        check_val("other_rdata", ply ? CPU_RDATA : PLY_RDATA, m_rdata[!ply]);
      end
    end
    set_req(ply, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge CLK); #1;
    check_val("idle_busy", 8'(BUSY), 8'd0);
    check_val("idle_ack", 8'(CPU_ACK | PLY_ACK), 8'd0);
    check_val("rdata_hold", ply ? PLY_RDATA : CPU_RDATA, exp_rd);
    if (wr) m_mem[addr] = wdata;
    m_rdata[ply] = exp_rd;
    m_di         = exp_di;
`ifdef ADDR_CACHE_EN
    if (lat_en) begin
      m_cache_vld  = 1'b1;
      m_cache_addr = addr;
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acks[$];
    int         at[$];
    logic [3:0] a;
    bit         p, w;

    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_bdir", 8'(BDIR), 8'd0);
    check_val("rst_bc", 8'(BC), 8'd0);
    check_val("rst_di", PSG_DI, 8'h00);
    check_val("rst_acks", 8'(CPU_ACK | PLY_ACK), 8'd0);
    check_val("rst_cpu_rdata", CPU_RDATA, 8'h00);
    check_val("rst_ply_rdata", PLY_RDATA, 8'h00);
    check_val("rst_busy", 8'(BUSY), 8'd0);
    RESET_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;

    // Fill every PSG register through the sequencer so reads are defined
    for (int i = 0; i < 16; i++)
      do_txn(1'(i), 1'b1, 4'(i), (i == 14) ? 8'hA5 : 8'($urandom));

    // Basic write and read
    do_txn(1'b0, 1'b1, 4'd7, 8'h38);
    do_txn(1'b0, 1'b0, 4'd14, 8'h00);
    check_val("read14_value", CPU_RDATA, 8'hA5);

    // Same-address back-to-back writes then a new address
    do_txn(1'b0, 1'b1, 4'd8, 8'h0F);
    do_txn(1'b0, 1'b1, 4'd8, 8'h10);
    do_txn(1'b0, 1'b1, 4'd9, 8'h5C);

    // Both requesters hold REQ from reset release: grants must alternate
    RESET_N = 1'b0;
    #1;
    set_req(1'b0, 1'b1, 1'b1, 4'd1, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 4'd2, 8'h22);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
    for (int k = 1; k <= 40 && acks.size() < 4; k++) begin
      @(posedge CLK); #1;
      check_val("alt_both_ack", 8'(CPU_ACK && PLY_ACK), 8'd0);
      if (CPU_ACK) begin acks.push_back(0); at.push_back(k); end
      if (PLY_ACK) begin acks.push_back(1); at.push_back(k); end
    end
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    check_val("alt_count", 8'(acks.size()), 8'd4);
    for (int i = 0; i < acks.size(); i++) begin
      check_val("alt_order", 8'(acks[i]), 8'(i % 2));
      check_val("alt_ack_cycle", 8'(at[i]), 8'(3 + 4 * i));
    end
    @(posedge CLK); #1;
    check_val("alt_idle_busy", 8'(BUSY), 8'd0);
    check_val("alt_idle_ack", 8'(CPU_ACK | PLY_ACK), 8'd0);
    m_mem[1]   = 8'h11;
    m_mem[2]   = 8'h22;
    m_di       = 8'h22;
`ifdef ADDR_CACHE_EN
    m_cache_vld  = 1'b1;
    m_cache_addr = 4'd2;
`endif

    // Reset during ACCESS of a read abandons it without ACK
    set_req(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_val("pre_rst_access_bc", 8'(BC), 8'd1);
    #2 RESET_N = 1'b0;
    #1;
    check_val("midrst_bdir", 8'(BDIR), 8'd0);
    check_val("midrst_bc", 8'(BC), 8'd0);
    check_val("midrst_busy", 8'(BUSY), 8'd0);
    check_val("midrst_ack", 8'(CPU_ACK), 8'd0);
    check_val("midrst_di", PSG_DI, 8'h00);
    check_val("midrst_cpu_rdata", CPU_RDATA, 8'h00);
    check_val("midrst_ply_rdata", PLY_RDATA, 8'h00);
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (2) begin
      @(posedge CLK); #1;
      check_val("midrst_no_ack", 8'(CPU_ACK | PLY_ACK), 8'd0);
    end
    RESET_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    do_txn(1'b0, 1'b0, 4'd3, 8'h00);

    // Randomized isolated transactions, biased toward repeated addresses
    a = 4'd0;
    for (int t = 0; t < 80; t++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) a = 4'($urandom_range(0, 15));
      do_txn(p, w, a, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
